// File: rtl/decoder_scan_pkg.sv
// Shared constants and state encoding for the scanning one-hot decoder.
package decoder_scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational SEL_W -> 2**SEL_W decoder.
// ACTIVE_LOW inverts the result to produce one-cold outputs.
module onehot_decoder #(
    parameter int SEL_W      = 3,
    parameter int ACTIVE_LOW = 0
) (
    input  logic [SEL_W-1:0]    sel_i,
    output logic [2**SEL_W-1:0] dec_o
);

    localparam int OUT_W = 2**SEL_W;

    logic [OUT_W-1:0] onehot;

    always_comb begin
        onehot        = '0;
        onehot[sel_i] = 1'b1;
        dec_o         = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with enable, polarity select and a scan mode
// that walks every output, holding each for DWELL clocks.
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 load,
    output logic [2**SEL_W-1:0]  D,
    output logic [SEL_W-1:0]     idx,
    output logic                 wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] D_INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic               wrap_q,  wrap_d;
    logic [OUT_W-1:0]   d_q,     d_d;
    logic [OUT_W-1:0]   dec;

    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    // Entry into SCAN and an explicit load share the reload path; load wins over advance.
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        case (state_d)
            DIRECT: begin
                idx_d   = sel;
                dwell_d = '0;
            end
            SCAN: begin
                if (state_q != SCAN || load) begin
                    idx_d   = sel;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    idx_d   = idx_q + SEL_W'(1);
                    dwell_d = '0;
                    wrap_d  = (idx_q == IDX_LAST);
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            default: begin
                idx_d   = idx_q;
                dwell_d = dwell_q;
            end
        endcase
    end

    onehot_decoder #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .sel_i (idx_d),
        .dec_o (dec)
    );

    assign d_d = (state_d == IDLE) ? D_INACTIVE : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            d_q     <= D_INACTIVE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            d_q     <= d_d;
        end
    end

    assign D    = d_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench: DUT A is active-high with DWELL=2, DUT B is active-low
// with DWELL=1; expectations are queued at stimulus time and checked by a monitor.
module tb_decoder_scan_n;

    typedef struct {
        int          dut;
        logic [7:0]  d;
        logic [2:0]  idx;
        logic        wrap;
        string       name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enA, modeA, loadA;
    logic [2:0] selA;
    logic [7:0] dA;
    logic [2:0] idxA;
    logic       wrapA;
    logic       enB, modeB, loadB;
    logic [2:0] selB;
    logic [7:0] dB;
    logic [2:0] idxB;
    logic       wrapB;

    exp_t expQ[$];
    int   nVec = 0;
    int   nMis = 0;

    decoder_scan_n #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(0)) dutA (
        .clk(clk), .rst_n(rst_n), .en(enA), .mode(modeA), .sel(selA),
        .load(loadA), .D(dA), .idx(idxA), .wrap(wrapA)
    );

    decoder_scan_n #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1)) dutB (
        .clk(clk), .rst_n(rst_n), .en(enB), .mode(modeB), .sel(selB),
        .load(loadB), .D(dB), .idx(idxB), .wrap(wrapB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (at a negedge), queue the post-edge expectation.
    task automatic applyStimulus(input int dut, input logic en, input logic mode,
                                 input logic [2:0] sel, input logic load,
                                 input logic [7:0] d, input logic [2:0] ix,
                                 input logic wr, input string name);
        exp_t e;
        if (dut == 0) begin
            enA = en; modeA = mode; selA = sel; loadA = load;
            enB = 1'b0;
        end else begin
            enB = en; modeB = mode; selB = sel; loadB = load;
            enA = 1'b0;
        end
        e.dut = dut; e.d = d; e.idx = ix; e.wrap = wr; e.name = name;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.dut == 0) begin
                    checkOutput({e.name, " D"},    32'(dA),    32'(e.d));
                    checkOutput({e.name, " idx"},  32'(idxA),  32'(e.idx));
                    checkOutput({e.name, " wrap"}, 32'(wrapA), 32'(e.wrap));
                end else begin
                    checkOutput({e.name, " D"},    32'(dB),    32'(e.d));
                    checkOutput({e.name, " idx"},  32'(idxB),  32'(e.idx));
                    checkOutput({e.name, " wrap"}, 32'(wrapB), 32'(e.wrap));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b1;
        enA = 1'b1; modeA = 1'b1; selA = 3'd6; loadA = 1'b0;
        enB = 1'b0; modeB = 1'b0; selB = 3'd0; loadB = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset D_A",    32'(dA),    32'h00);
        checkOutput("reset idx_A",  32'(idxA),  32'h0);
        checkOutput("reset wrap_A", 32'(wrapA), 32'h0);
        checkOutput("reset D_B",    32'(dB),    32'hFF);
        @(negedge clk);
        @(negedge clk);
        checkOutput("held reset D_A",   32'(dA),   32'h00);
        checkOutput("held reset idx_A", 32'(idxA), 32'h0);

        rst_n = 1'b1;
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h40, 3'd6, 0, "scan entry");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h40, 3'd6, 0, "dwell 6b");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h80, 3'd7, 0, "adv 7a");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h80, 3'd7, 0, "dwell 7b");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h01, 3'd0, 1, "wrap to 0");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h01, 3'd0, 0, "wrap drop");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h02, 3'd1, 0, "adv 1a");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h02, 3'd1, 0, "dwell 1b");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h04, 3'd2, 0, "adv 2a");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h04, 3'd2, 0, "dwell 2b");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h08, 3'd3, 0, "adv 3a");
        applyStimulus(0, 1, 1, 3'd6, 0, 8'h08, 3'd3, 0, "dwell 3b");
        applyStimulus(0, 1, 1, 3'd0, 1, 8'h01, 3'd0, 0, "load beats adv");
        applyStimulus(0, 1, 1, 3'd0, 0, 8'h01, 3'd0, 0, "load hold");
        applyStimulus(0, 1, 1, 3'd0, 0, 8'h02, 3'd1, 0, "post-load adv");

        applyStimulus(0, 1, 0, 3'd5, 0, 8'h20, 3'd5, 0, "direct 5");
        applyStimulus(0, 1, 0, 3'd2, 0, 8'h04, 3'd2, 0, "direct 2");
        applyStimulus(0, 1, 1, 3'd2, 0, 8'h04, 3'd2, 0, "direct->scan");
        applyStimulus(0, 1, 1, 3'd2, 0, 8'h04, 3'd2, 0, "scan dwell");
        applyStimulus(0, 1, 1, 3'd2, 0, 8'h08, 3'd3, 0, "scan adv");

        applyStimulus(0, 0, 1, 3'd4, 1, 8'h00, 3'd3, 0, "en drop");
        applyStimulus(0, 0, 0, 3'd4, 1, 8'h00, 3'd3, 0, "idle hold");
        applyStimulus(0, 1, 1, 3'd5, 0, 8'h20, 3'd5, 0, "re-enable reload");
        applyStimulus(0, 1, 1, 3'd5, 0, 8'h20, 3'd5, 0, "reload dwell");
        applyStimulus(0, 1, 1, 3'd5, 0, 8'h40, 3'd6, 0, "reload adv");

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset D_A",    32'(dA),    32'h00);
        checkOutput("async reset idx_A",  32'(idxA),  32'h0);
        checkOutput("async reset wrap_A", 32'(wrapA), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 1, 3'd1, 0, 8'h02, 3'd1, 0, "restart entry");
        applyStimulus(0, 1, 1, 3'd1, 0, 8'h02, 3'd1, 0, "restart dwell");
        applyStimulus(0, 1, 1, 3'd1, 0, 8'h04, 3'd2, 0, "restart adv");

        applyStimulus(1, 1, 0, 3'd0, 0, 8'hFE, 3'd0, 0, "lo direct 0");
        applyStimulus(1, 0, 0, 3'd0, 0, 8'hFF, 3'd0, 0, "lo disabled");
        applyStimulus(1, 1, 1, 3'd7, 0, 8'h7F, 3'd7, 0, "lo scan entry");
        applyStimulus(1, 1, 1, 3'd7, 0, 8'hFE, 3'd0, 1, "lo wrap dwell1");
        applyStimulus(1, 1, 1, 3'd7, 0, 8'hFD, 3'd1, 0, "lo adv dwell1");

        @(negedge clk);
        @(negedge clk);
        checkOutput("queue drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
